// File: rtl/alu_register.sv
// alu_register: combinational 4-bit ALU alongside a 4-bit register with prioritised clear/load/inc/dec/shift.
// Build option ALU_REGISTER_MULDIV_EN enables MUL (010) and DIV (011); without it those opcodes return 0.
module alu_register (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] oc,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] f,
    input  logic       cl,
    input  logic       ld,
    input  logic [3:0] in,
    input  logic       inc,
    input  logic       dec,
    input  logic       sr,
    input  logic       ir,
    input  logic       sl,
    input  logic       il,
    output logic [3:0] out
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_OR  = 3'b110,
        OP_AND = 3'b111
    } alu_op_t;

    alu_op_t op;
    assign op = alu_op_t'(oc);

    always_comb begin
        f = '0;
        case (op)
            OP_ADD: f = a + b;
            OP_SUB: f = a - b;
`ifdef ALU_REGISTER_MULDIV_EN
            OP_MUL: f = a * b;
            // Divide-by-zero is forced to all-ones so f never goes X.
            OP_DIV: f = (b == '0) ? '1 : a / b;
`else
            OP_MUL: f = '0;
            OP_DIV: f = '0;
`endif
            OP_NOT: f = ~a;
            OP_XOR: f = a ^ b;
            OP_OR:  f = a | b;
            OP_AND: f = a & b;
            default: f = '0;
        endcase
    end

    // Priority chain: cl > ld > inc > dec > sr > sl; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (cl) begin
            out <= '0;
        end else if (ld) begin
            out <= in;
        end else if (inc) begin
            out <= out + 4'd1;
        end else if (dec) begin
            out <= out - 4'd1;
        end else if (sr) begin
            out <= {ir, out[3:1]};
        end else if (sl) begin
            out <= {out[2:0], il};
        end
    end

endmodule

// File: tb/tb_alu_register.sv
// Scoreboard bench for alu_register: stimulus queues expected values, a monitor pops and compares.
// Expectations for opcodes 010/011 follow ALU_REGISTER_MULDIV_EN as defined for this build.
module tb_alu_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] oc;
  logic [3:0] a, b, f;
  logic       cl, ld, inc, dec, sr, ir, sl, il;
  logic [3:0] in, out;

  alu_register dut (
    .clk(clk), .rst_n(rst_n), .oc(oc), .a(a), .b(b), .f(f),
    .cl(cl), .ld(ld), .in(in), .inc(inc), .dec(dec),
    .sr(sr), .ir(ir), .sl(sl), .il(il), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_reg;
    logic [3:0] exp;
    string      tag;
  } item_t;

  item_t       sb[$];
  event        check_ev;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [3:0]  model;

  function automatic logic [3:0] alu_model(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    int ix, iy, r;
    ix = int'(x);
    iy = int'(y);
    r = 0;
    case (op)
      3'd0: r = (ix + iy) % 16;
      3'd1: r = (ix - iy + 16) % 16;
`ifdef ALU_REGISTER_MULDIV_EN
      3'd2: r = (ix * iy) % 16;
      3'd3: r = (iy == 0) ? 15 : ix / iy;
`else
      3'd2: r = 0;
      3'd3: r = 0;
`endif
      3'd4: r = 15 - ix;
      3'd5: r = ix ^ iy;
      3'd6: r = ix | iy;
      3'd7: r = ix & iy;
      default: r = 0;
    endcase
    return r[3:0];
  endfunction

  // ctrl = {cl, ld, inc, dec, sr, ir, sl, il}
  function automatic logic [3:0] reg_model(input logic [3:0] cur, input logic [7:0] c, input logic [3:0] d);
    int v, r;
    v = int'(cur);
    if (c[7])      r = 0;
    else if (c[6]) r = int'(d);
    else if (c[5]) r = (v + 1) % 16;
    else if (c[4]) r = (v + 15) % 16;
    else if (c[3]) r = (c[2] ? 8 : 0) + v / 2;
    else if (c[1]) r = (v * 2 + (c[0] ? 1 : 0)) % 16;
    else           r = v;
    return r[3:0];
  endfunction

  initial begin : monitor
    item_t it;
    logic [3:0] act;
    forever begin
      @(check_ev);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        act = it.is_reg ? out : f;
        n_checks++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b", it.tag, act, it.exp);
        end
      end
    end
  end

  task automatic push(input bit is_reg, input logic [3:0] e, input string tag);
    sb.push_back('{is_reg, e, tag});
    -> check_ev;
    #1;
  endtask

  task automatic cycle(input logic [7:0] c, input logic [3:0] d, input string tag);
    @(negedge clk);
    {cl, ld, inc, dec, sr, ir, sl, il} = c;
    in = d;
    model = reg_model(model, c, d);
    @(posedge clk);
    #1;
    push(1'b1, model, tag);
  endtask

  task automatic alu_spot(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y,
                          input logic [3:0] e, input string tag);
    oc = op; a = x; b = y;
    #1;
    push(1'b0, e, tag);
    #8;
  endtask

  localparam logic [7:0] C_CL  = 8'b1000_0000;
  localparam logic [7:0] C_LD  = 8'b0100_0000;
  localparam logic [7:0] C_INC = 8'b0010_0000;
  localparam logic [7:0] C_DEC = 8'b0001_0000;
  localparam logic [7:0] C_SR  = 8'b0000_1000;
  localparam logic [7:0] C_IR  = 8'b0000_0100;
  localparam logic [7:0] C_SL  = 8'b0000_0010;
  localparam logic [7:0] C_IL  = 8'b0000_0001;

  initial begin : stimulus
    logic [7:0] rc;
    logic [3:0] rd;
    logic [10:0] v;
    rst_n = 1'b0;
    {cl, ld, inc, dec, sr, ir, sl, il} = '0;
    in = '0; oc = '0; a = '0; b = '0;
    model = '0;
    #2;
    push(1'b1, 4'b0000, "reset_state");
    n_checks++;
    if (out !== 4'b0000) begin
      n_fail++;
      $display("FAIL direct reset_state: got %b expected 0000", out);
    end
    @(negedge clk);
    rst_n = 1'b1;

    cycle('0, 4'd0, "idle_hold");

    for (int unsigned i = 0; i < 2048; i++) begin
      v = i[10:0];
      {oc, a, b} = v;
      #1;
      push(1'b0, alu_model(oc, a, b), $sformatf("alu_sweep oc=%b a=%b b=%b", oc, a, b));
      #8;
    end

    alu_spot(3'b000, 4'b1111, 4'b0001, 4'b0000, "spot_add_wrap");
    alu_spot(3'b001, 4'b0000, 4'b0001, 4'b1111, "spot_sub_wrap");
    alu_spot(3'b100, 4'b0101, 4'b0000, 4'b1010, "spot_not");
    alu_spot(3'b101, 4'b1100, 4'b1010, 4'b0110, "spot_xor");
`ifdef ALU_REGISTER_MULDIV_EN
    alu_spot(3'b011, 4'b1001, 4'b0010, 4'b0100, "spot_div");
    alu_spot(3'b011, 4'b0101, 4'b0000, 4'b1111, "spot_div_zero");
    oc = 3'b011; a = 4'b0101; b = 4'b0000;
    #1;
    n_checks++;
    if (f !== 4'b1111) begin
      n_fail++;
      $display("FAIL direct div_zero: got %b expected 1111", f);
    end
    alu_spot(3'b010, 4'b0011, 4'b0101, 4'b1111, "spot_mul_trunc");
`else
    alu_spot(3'b011, 4'b1001, 4'b0010, 4'b0000, "spot_div_disabled");
    alu_spot(3'b011, 4'b0101, 4'b0000, 4'b0000, "spot_div_zero_disabled");
    oc = 3'b011; a = 4'b0101; b = 4'b0000;
    #1;
    n_checks++;
    if (f !== 4'b0000) begin
      n_fail++;
      $display("FAIL direct div_disabled: got %b expected 0000", f);
    end
    alu_spot(3'b010, 4'b0011, 4'b0101, 4'b0000, "spot_mul_disabled");
`endif

    cycle(C_LD, 4'b1010, "load_1010");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model = '0;
    #1;
    push(1'b1, 4'b0000, "rst_async_before_edge");
    n_checks++;
    if (out !== 4'b0000) begin
      n_fail++;
      $display("FAIL direct rst_async: got %b expected 0000", out);
    end
    ld = 1'b1; in = 4'b1111;
    @(posedge clk);
    #1;
    push(1'b1, 4'b0000, "rst_hold_over_load");
    @(negedge clk);
    rst_n = 1'b1;
    ld = 1'b0;
    cycle(C_LD, 4'b0110, "rst_release_load");
    n_checks++;
    if (out !== 4'b0110) begin
      n_fail++;
      $display("FAIL direct rst_release_load: got %b expected 0110", out);
    end

    cycle(C_LD, 4'b1111, "load_1111");
    cycle(C_INC, 4'd0, "inc_wrap");
    n_checks++;
    if (out !== 4'b0000) begin
      n_fail++;
      $display("FAIL direct inc_wrap: got %b expected 0000", out);
    end
    cycle(C_DEC, 4'd0, "dec_wrap");
    n_checks++;
    if (out !== 4'b1111) begin
      n_fail++;
      $display("FAIL direct dec_wrap: got %b expected 1111", out);
    end

    cycle(C_LD, 4'b1001, "load_1001");
    cycle(C_SR | C_IR, 4'd0, "sr_ir1");
    n_checks++;
    if (out !== 4'b1100) begin
      n_fail++;
      $display("FAIL direct sr_ir1: got %b expected 1100", out);
    end
    cycle(C_SL, 4'd0, "sl_il0");
    n_checks++;
    if (out !== 4'b1000) begin
      n_fail++;
      $display("FAIL direct sl_il0: got %b expected 1000", out);
    end

    cycle(C_CL | C_LD | C_INC, 4'b0101, "prio_cl_ld_inc");
    n_checks++;
    if (out !== 4'b0000) begin
      n_fail++;
      $display("FAIL direct prio_cl_ld_inc: got %b expected 0000", out);
    end
    cycle(C_LD | C_INC, 4'b0101, "prio_ld_inc");
    n_checks++;
    if (out !== 4'b0101) begin
      n_fail++;
      $display("FAIL direct prio_ld_inc: got %b expected 0101", out);
    end
    cycle(C_LD, 4'b0100, "load_0100");
    cycle(C_DEC | C_SR, 4'd0, "prio_dec_sr");
    n_checks++;
    if (out !== 4'b0011) begin
      n_fail++;
      $display("FAIL direct prio_dec_sr: got %b expected 0011", out);
    end
    cycle(C_IR | C_IL, 4'd0, "hold_ignores_serial");
    n_checks++;
    if (out !== 4'b0011) begin
      n_fail++;
      $display("FAIL direct hold: got %b expected 0011", out);
    end

    for (int unsigned i = 0; i < 1000; i++) begin
      rc = '0;
      rc[7] = ($urandom_range(0, 9) == 0);
      rc[6] = ($urandom_range(0, 4) == 0);
      rc[5] = ($urandom_range(0, 3) == 0);
      rc[4] = ($urandom_range(0, 3) == 0);
      rc[3] = ($urandom_range(0, 2) == 0);
      rc[2] = $urandom_range(0, 1) == 1;
      rc[1] = ($urandom_range(0, 2) == 0);
      rc[0] = $urandom_range(0, 1) == 1;
      rd = 4'($urandom_range(0, 15));
      cycle(rc, rd, $sformatf("random[%0d] ctrl=%b in=%b", i, rc, rd));
    end

    @(negedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: got %0d pending expected 0", sb.size());
    end
    if (n_checks == 0) begin
      n_fail++;
      $display("FAIL checks: got 0 evaluated expected nonzero");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/alu_register.md
ALU_REGISTER -- requirements
Module: alu_register

Interface
- REQ-001 The block SHALL have no parameters; all data widths are fixed at 4 bits and the opcode width at 3 bits.
- REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named `clk` and `rst_n` as in the codebase.
- REQ-003 clk  input  1  clock; all register updates occur on its rising edge.
- REQ-004 rst_n  input  1  asynchronous active-low reset of the register.
- REQ-005 oc  input  3  ALU opcode.
- REQ-006 a  input  4  ALU operand A, unsigned.
- REQ-007 b  input  4  ALU operand B, unsigned.
- REQ-008 f  output  4  ALU result; combinational.
- REQ-009 cl  input  1  register clear request.
- REQ-010 ld  input  1  register parallel-load request.
- REQ-011 in  input  4  register parallel-load data.
- REQ-012 inc  input  1  register increment request.
- REQ-013 dec  input  1  register decrement request.
- REQ-014 sr  input  1  register shift-right request.
- REQ-015 ir  input  1  serial input bit for shift right; enters at MSB.
- REQ-016 sl  input  1  register shift-left request.
- REQ-017 il  input  1  serial input bit for shift left; enters at LSB.
- REQ-018 out  output  4  register contents.

Function
- REQ-019 The ALU SHALL be purely combinational: f updates in the same delta as any change to oc, a or b, with zero cycles of latency.
- REQ-020 The ALU opcodes SHALL be decoded as follows; all results are truncated to the low 4 bits and carry/overflow is discarded:
  - 000: f = a+b mod 16
  - 001: f = a-b mod 16
  - 010: f = (a*b)[3:0]
  - 011: f = a/b (integer quotient)
  - 100: f = ~a
  - 101: f = a^b
  - 110: f = a|b
  - 111: f = a&b
- REQ-021 Division by zero (oc=011, b=0) SHALL yield f=4'b1111.
- REQ-022 The ALU SHALL be independent of clk and rst_n, and its output SHALL never be X when its inputs are known.
- REQ-023 On each rising clk edge with rst_n=1, the register SHALL perform exactly one operation, chosen by the fixed priority cl > ld > inc > dec > sr > sl.
- REQ-024 The register operations SHALL be:
  - cl: out <= 0000
  - ld: out <= in
  - inc: out <= out+1 mod 16
  - dec: out <= out-1 mod 16
  - sr: out <= {ir, out[3:1]}
  - sl: out <= {out[2:0], il}
- REQ-025 Increment and decrement SHALL wrap around: inc at 1111 gives 0000, and dec at 0000 gives 1111.
- REQ-026 When no control input is asserted, the register SHALL hold its value; ir and il are ignored unless their shift is the selected operation.
- REQ-027 When several control inputs are asserted simultaneously, only the highest-priority operation SHALL take effect; for example cl=1 with ld=1 clears the register.
- REQ-028 out SHALL be driven directly from the state flops, one cycle after the controls are sampled.

Reset
- REQ-029 rst_n=0 SHALL force out to 0000 immediately, without waiting for a clock edge, and SHALL hold it there while asserted, overriding all controls.
- REQ-030 Deasserting rst_n SHALL have no effect until the next rising clk edge, which then applies REQ-023; reset asserted mid-operation discards any pending operation.
- REQ-031 The ALU SHALL have no reset dependence.

Configuration
- REQ-032 The macro ALU_REGISTER_MULDIV_EN SHALL control the multiply and divide opcodes:
  - Defined: opcodes 010 and 011 implement MUL and DIV as in REQ-020 and REQ-021.
  - Undefined: opcodes 010 and 011 yield f=0000 and no multiplier or divider logic is synthesized.
  - All other opcodes and the whole register behave identically in both builds.

Verification
- REQ-033 Exhaustive ALU sweep: all 2048 combinations of {oc,a,b} applied at 10 ns steps -> f matches REQ-020 for each; spot checks 000/1111/0001 -> 0000, 001/0000/0001 -> 1111, 011/1001/0010 -> 0100, 011/0101/0000 -> 1111.
- REQ-034 Reset: rst_n=0 mid-cycle with out=1010 -> out=0000 before the next edge; after release, ld=1 with in=0110 -> out=0110 on the following edge.
- REQ-035 Wrap-around: load 1111, then inc -> 0000; then dec -> 1111.
- REQ-036 Shifts: load 1001, then sr with ir=1 -> 1100; then sl with il=0 -> 1000.
- REQ-037 Priority: cl=ld=inc=1, in=0101 -> 0000; ld=inc=1, in=0101 -> 0101; dec=sr=1 from 0100 -> 0011; no controls -> value held.
- REQ-038 Random regression: 1000 cycles of random in, controls, ir and il, checked every cycle against a reference model of REQ-023 to REQ-027.
